// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// channel id width and default vector-table placement.
package vic_pkg;

  localparam int ID_W = 4;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } vic_state_e;

endpackage

// File: rtl/vic_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: id is the smallest set bit of req,
// valid flags that any bit is set.
module prio_enc
  import vic_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]  req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Scan from the top down so the last (lowest) hit wins.
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/vic_ctrl.sv
// Vectored interrupt controller: latches interrupt events, masks them, and
// hands the lowest-index winner to the core through a req/ack/ret handshake.
module vic_ctrl
  import vic_pkg::*;
#(
  parameter int              NCH        = 4,
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   BASE_ADDR  = AW'(DEF_BASE_ADDR),
  parameter logic [AW-1:0]   VEC_STRIDE = AW'(DEF_VEC_STRIDE),
  parameter bit              EDGE       = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  irq_in,
  input  logic            mask_we,
  input  logic [NCH-1:0]  mask_wd,
  input  logic            gie,
  output logic            int_req,
  input  logic            int_ack,
  input  logic            int_ret,
  output logic [AW-1:0]   vector_addr,
  output logic [ID_W-1:0] active_id,
  output logic            in_service,
  output logic [NCH-1:0]  pending,
  output vic_state_e      state_dbg
);

  // Handshake: int_req stays high from entering REQ until the cycle int_ack
  // is seen high (the transfer cycle); vector_addr/active_id are stable for
  // the whole time int_req is high. int_ret ends the handler from SERVICE.

  vic_state_e     state_q, state_d;
  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] cand;
  logic [NCH-1:0] clr_vec;
  logic [ID_W-1:0] id_q;
  logic [AW-1:0]  vec_q;
  logic [ID_W-1:0] win_id;
  logic           win_valid;
  logic [AW-1:0]  win_vec;
  logic           grant;
  logic           ack_take;

  assign cand = pend_q & mask_q;

  prio_enc #(.NCH(NCH)) u_prio (
    .req   (cand),
    .id    (win_id),
    .valid (win_valid)
  );

  // AW-bit arithmetic wraps naturally, giving the modulo-2^AW address.
  assign win_vec  = BASE_ADDR + VEC_STRIDE * AW'(win_id);
  assign ack_take = (state_q == ST_REQ) && int_ack;
  assign clr_vec  = ack_take ? (NCH'(1) << id_q) : '0;

  generate
    if (EDGE) begin : g_edge
      // Set term is OR'd after the clear so a new edge on the ack cycle survives.
      assign pend_d = (pend_q & ~clr_vec) | (irq_in & ~prev_q);
    end else begin : g_level
      assign pend_d = irq_in;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gie && win_valid) begin
          state_d = ST_REQ;
          grant   = 1'b1;
        end
      end
      ST_REQ: begin
        if (int_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (int_ret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '1;
      pend_q  <= '0;
      prev_q  <= '0;
      id_q    <= '0;
      vec_q   <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= irq_in;
      if (mask_we) mask_q <= mask_wd;
      if (grant) begin
        id_q  <= win_id;
        vec_q <= win_vec;
      end
    end
  end

  assign int_req     = (state_q == ST_REQ);
  assign in_service  = (state_q == ST_SERVICE);
  assign active_id   = id_q;
  assign vector_addr = vec_q;
  assign pending     = pend_q;
  assign state_dbg   = state_q;

endmodule
